diff_response_monitor: RTL and testbench

- Response-side companion to a generated fuzz DUT.
- Consumes the packed 47-bit `y` result vectors from two builds of the same design: a reference (golden) build and a build under test.
- Over a programmed run it compacts the DUT responses into a MISR signature, counts per-cycle mismatches, and captures the first failing cycle and its XOR syndrome.
- Results are held for the differential-timing harness to read.

---
 rtl/diff_mon_pkg.sv | 21 ++
 rtl/diff_response_monitor_if.sv | 28 ++
 rtl/diff_misr.sv | 38 +++
 rtl/diff_response_monitor.sv | 145 ++++++++++++++
 tb/tb_diff_response_monitor.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/diff_mon_pkg.sv
// Shared types and constants for the differential response monitor.
// Holds the run-state encoding, default MISR constants and the response fold.
package diff_mon_pkg;

  localparam int          Y_W_DEF      = 47;
  localparam logic [31:0] SIG_POLY_DEF = 32'h04C11DB7;
  localparam logic [31:0] SIG_SEED_DEF = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } mon_state_e;

  // Upper 15 bits of the response are folded onto the low word before compaction
  function automatic logic [31:0] fold_y(input logic [Y_W_DEF-1:0] y);
    return y[31:0] ^ {17'b0, y[Y_W_DEF-1:32]};
  endfunction

endpackage

// File: rtl/diff_response_monitor_if.sv
// Run-control and result bundle between the timing harness and the monitor.
// The harness side is the master; the monitor side is the slave.
interface diff_response_monitor_if #(
  parameter int Y_W = 47
);
  logic           start;
  logic [Y_W-1:0] y_ref;
  logic [Y_W-1:0] y_dut;
  logic           busy;
  logic           done;
  logic           mismatch;
  logic [15:0]    fail_count;
  logic [15:0]    first_fail_cycle;
  logic [Y_W-1:0] first_fail_xor;
  logic [31:0]    signature;

  modport master (
    output start, y_ref, y_dut,
    input  busy, done, mismatch, fail_count, first_fail_cycle,
           first_fail_xor, signature
  );

  modport slave (
    input  start, y_ref, y_dut,
    output busy, done, mismatch, fail_count, first_fail_cycle,
           first_fail_xor, signature
  );
endinterface

// File: rtl/diff_misr.sv
// 32-bit multiple-input signature register with seed load and step enable.
// Load has priority over enable so a restart edge always lands on the seed.
module diff_misr
  import diff_mon_pkg::*;
#(
  parameter logic [31:0] POLY = SIG_POLY_DEF,
  parameter logic [31:0] SEED = SIG_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  output logic [31:0] sig_o
);

  logic [31:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (en_i) begin
      sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/diff_response_monitor.sv
// Compares golden and under-test response streams over a programmed run.
// Define MONITOR_STOP_ON_FAIL_EN to end a run on its first mismatching cycle.
//
// state     | meaning
// ST_IDLE   | no run since reset; waiting for start
// ST_WARMUP | pipeline fill, responses ignored
// ST_RUN    | comparing and compacting, index 0..RUN_LEN-1
// ST_DONE   | results held until start or rst
module diff_response_monitor
  import diff_mon_pkg::*;
#(
  parameter int          Y_W      = Y_W_DEF,
  parameter int          RUN_LEN  = 256,
  parameter int          WARMUP   = 2,
  parameter logic [31:0] SIG_POLY = SIG_POLY_DEF,
  parameter logic [31:0] SIG_SEED = SIG_SEED_DEF
) (
  input logic                     clk,
  input logic                     rst,
  diff_response_monitor_if.slave  mon
);

`ifdef MONITOR_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [15:0] RUN_LAST  = 16'(RUN_LEN - 1);
  localparam logic [15:0] WARM_LAST = 16'((WARMUP > 0) ? (WARMUP - 1) : 0);

  mon_state_e     state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           mismatch_q, mismatch_d;
  logic [15:0]    fail_cnt_q, fail_cnt_d;
  logic [15:0]    ff_cycle_q, ff_cycle_d;
  logic [Y_W-1:0] ff_xor_q, ff_xor_d;

  logic           cyc_diff;
  logic [Y_W-1:0] cyc_syn;
  logic           misr_load;
  logic           misr_en;
  logic [31:0]    misr_sig;

  assign cyc_syn  = mon.y_ref ^ mon.y_dut;
  assign cyc_diff = (cyc_syn != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mismatch_d = mismatch_q;
    fail_cnt_d = fail_cnt_q;
    ff_cycle_d = ff_cycle_q;
    ff_xor_d   = ff_xor_q;
    misr_load  = 1'b0;
    misr_en    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (mon.start) begin
          state_d    = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
          cnt_d      = '0;
          mismatch_d = 1'b0;
          fail_cnt_d = '0;
          ff_cycle_d = '0;
          ff_xor_d   = '0;
          misr_load  = 1'b1;
        end
      end

      ST_WARMUP: begin
        if (cnt_q == WARM_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_RUN: begin
        misr_en = 1'b1;
        if (cyc_diff) begin
          mismatch_d = 1'b1;
          if (fail_cnt_q != 16'hFFFF) begin
            fail_cnt_d = fail_cnt_q + 16'd1;
          end
          // Only the earliest failing cycle is kept
          if (!mismatch_q) begin
            ff_cycle_d = cnt_q;
            ff_xor_d   = cyc_syn;
          end
        end
        if ((cnt_q == RUN_LAST) || (STOP_ON_FAIL && cyc_diff)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mismatch_q <= 1'b0;
      fail_cnt_q <= '0;
      ff_cycle_q <= '0;
      ff_xor_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mismatch_q <= mismatch_d;
      fail_cnt_q <= fail_cnt_d;
      ff_cycle_q <= ff_cycle_d;
      ff_xor_q   <= ff_xor_d;
    end
  end

  diff_misr #(
    .POLY (SIG_POLY),
    .SEED (SIG_SEED)
  ) u_misr (
    .clk    (clk),
    .rst    (rst),
    .load_i (misr_load),
    .en_i   (misr_en),
    .data_i (fold_y(mon.y_dut)),
    .sig_o  (misr_sig)
  );

  assign mon.busy             = (state_q == ST_WARMUP) || (state_q == ST_RUN);
  assign mon.done             = (state_q == ST_DONE);
  assign mon.mismatch         = mismatch_q;
  assign mon.fail_count       = fail_cnt_q;
  assign mon.first_fail_cycle = ff_cycle_q;
  assign mon.first_fail_xor   = ff_xor_q;
  assign mon.signature        = misr_sig;

endmodule

// File: tb/tb_diff_response_monitor.sv
// Directed bench for diff_response_monitor with RUN_LEN=8, WARMUP=2.
// Define MONITOR_STOP_ON_FAIL_EN for both bench and RTL to exercise early stop.
module tb_diff_response_monitor;

`ifdef MONITOR_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [46:0] syn [0:7];
  logic [31:0] sig1;
  logic [31:0] sig_tmp;

  diff_response_monitor_if #(.Y_W(47)) mon_if ();

  diff_response_monitor #(
    .Y_W     (47),
    .RUN_LEN (8),
    .WARMUP  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [46:0] y);
    logic [31:0] f;
    f = y[31:0] ^ {17'b0, y[46:32]};
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_syn();
    for (int i = 0; i < 8; i++) syn[i] = '0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 64'(mon_if.busy), 64'd0);
    chk({tag, "_done"}, 64'(mon_if.done), 64'd0);
    chk({tag, "_mismatch"}, 64'(mon_if.mismatch), 64'd0);
    chk({tag, "_fail_count"}, 64'(mon_if.fail_count), 64'd0);
    chk({tag, "_ff_cycle"}, 64'(mon_if.first_fail_cycle), 64'd0);
    chk({tag, "_ff_xor"}, 64'(mon_if.first_fail_xor), 64'd0);
    chk({tag, "_sig"}, 64'(mon_if.signature), 64'(SEED));
  endtask

  // One run: start edge, then up to 10 cycles where y_ref counts 0..9 and
  // y_dut = y_ref ^ syn[index]; warmup cycles carry deliberate garbage on y_dut.
  task automatic do_run(input string tag, input logic [15:0] exp_fc,
                        input logic [15:0] exp_ffc, input logic [46:0] exp_ffx,
                        input int exp_busy, input int start_at,
                        output logic [31:0] sig_o);
    logic [31:0] msig;
    logic [46:0] yd;
    int          busy_cnt;
    mon_if.start = 1'b1;
    mon_if.y_ref = '0;
    mon_if.y_dut = 47'h3;
    @(posedge clk); #1;
    mon_if.start = 1'b0;
    chk({tag, "_start_busy"}, 64'(mon_if.busy), 64'd1);
    chk({tag, "_start_mismatch"}, 64'(mon_if.mismatch), 64'd0);
    chk({tag, "_start_fc"}, 64'(mon_if.fail_count), 64'd0);
    chk({tag, "_start_ffc"}, 64'(mon_if.first_fail_cycle), 64'd0);
    chk({tag, "_start_ffx"}, 64'(mon_if.first_fail_xor), 64'd0);
    chk({tag, "_start_sig"}, 64'(mon_if.signature), 64'(SEED));
    msig     = SEED;
    busy_cnt = 1;
    for (int c = 0; c < 10; c++) begin
      yd = (c >= 2) ? (47'(c) ^ syn[c-2]) : (47'(c) ^ 47'h7FFF_0000_0001);
      mon_if.y_ref = 47'(c);
      mon_if.y_dut = yd;
      mon_if.start = (c == start_at);
      @(posedge clk); #1;
      mon_if.start = 1'b0;
      if (c >= 2) msig = misr_step(msig, yd);
      if (mon_if.busy) busy_cnt++;
      else break;
    end
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    chk({tag, "_done"}, 64'(mon_if.done), 64'd1);
    chk({tag, "_mismatch"}, 64'(mon_if.mismatch), 64'(exp_fc != 16'd0));
    chk({tag, "_fail_count"}, 64'(mon_if.fail_count), 64'(exp_fc));
    chk({tag, "_ff_cycle"}, 64'(mon_if.first_fail_cycle), 64'(exp_ffc));
    chk({tag, "_ff_xor"}, 64'(mon_if.first_fail_xor), 64'(exp_ffx));
    chk({tag, "_sig"}, 64'(mon_if.signature), 64'(msig));
    mon_if.y_ref = 47'h1234;
    mon_if.y_dut = 47'h4321;
    @(posedge clk); #1;
    chk({tag, "_hold_done"}, 64'(mon_if.done), 64'd1);
    chk({tag, "_hold_sig"}, 64'(mon_if.signature), 64'(msig));
    chk({tag, "_hold_fc"}, 64'(mon_if.fail_count), 64'(exp_fc));
    sig_o = msig;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    mon_if.start = 1'b0;
    mon_if.y_ref = '0;
    mon_if.y_dut = '0;
    clear_syn();
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_start", 64'(mon_if.busy), 64'd0);

    // Scenario 1: identical streams
    clear_syn();
    do_run("s1", 16'd0, 16'd0, 47'd0, 10, -1, sig1);

    // Scenario 2: single flip at index 5
    clear_syn();
    syn[5] = 47'h1_0000_0000;
    do_run("s2", 16'd1, 16'd5, 47'h1_0000_0000, STOP ? 8 : 10, -1, sig_tmp);

    // Scenario 3: flips at 3, 4, 7
    clear_syn();
    syn[3] = 47'h0000_0000_00F0;
    syn[4] = 47'h4000_0000_0000;
    syn[7] = 47'h0000_0001_2340;
    do_run("s3", STOP ? 16'd1 : 16'd3, 16'd3, 47'h0000_0000_00F0, STOP ? 6 : 10, -1, sig_tmp);

    // Scenario 4: flip on the last index
    clear_syn();
    syn[7] = 47'h0000_0000_0001;
    do_run("s4", 16'd1, 16'd7, 47'h0000_0000_0001, 10, -1, sig_tmp);

    // Scenario 4b: flip at index 2 (early stop when enabled)
    clear_syn();
    syn[2] = 47'h2000_0000_0008;
    do_run("s4b", 16'd1, 16'd2, 47'h2000_0000_0008, STOP ? 5 : 10, -1, sig_tmp);

    // Scenario 5b: start while busy is ignored
    clear_syn();
    do_run("s5b", 16'd0, 16'd0, 47'd0, 10, 5, sig_tmp);
    chk("s5b_sig_vs_s1", 64'(sig_tmp), 64'(sig1));

    // Scenario 5: reset at index 4 of a failing run
    clear_syn();
    syn[1] = 47'h0000_0000_0100;
    mon_if.start = 1'b1;
    @(posedge clk); #1;
    mon_if.start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mon_if.y_ref = 47'(c);
      mon_if.y_dut = (c >= 2) ? (47'(c) ^ syn[c-2]) : 47'(c);
      @(posedge clk); #1;
    end
    chk("s5_pre_rst_mismatch", 64'(mon_if.mismatch), 64'd1);
    rst = 1'b1;
    mon_if.y_ref = 47'd6;
    mon_if.y_dut = 47'd7;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset("s5_rst");
    repeat (3) @(posedge clk);
    #1;
    chk("s5_stay_idle_busy", 64'(mon_if.busy), 64'd0);
    chk("s5_stay_idle_sig", 64'(mon_if.signature), 64'(SEED));

    // Scenario 6: failing run, then clean restart from DONE
    clear_syn();
    syn[0] = 47'h7FFF_FFFF_FFFF;
    do_run("s6a", 16'd1, 16'd0, 47'h7FFF_FFFF_FFFF, STOP ? 3 : 10, -1, sig_tmp);
    clear_syn();
    do_run("s6", 16'd0, 16'd0, 47'd0, 10, -1, sig_tmp);
    chk("s6_sig_vs_s1", 64'(sig_tmp), 64'(sig1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
